memory_bus_arbiter: RTL and testbench

- Shares the unified memory bus between two requesters: port m0 (CPU fetch/load-store sequencer) and port m1 (program loader).
- The bus drives both memories with a shared address, write data, read enable and write enable:
  - address[13]=1 selects the instruction memory (27-bit words, 8K deep).
  - address[13]=0 selects the data memory (24-bit words).
- Each transaction is a fixed 4-cycle sequence. Round-robin arbitration applies when both ports request in the same cycle.

---
 rtl/memory_bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_memory_bus_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter sharing the unified memory bus between m0 (CPU) and m1 (loader).
// Every transaction runs IDLE -> ACCESS -> CAPTURE -> DONE, one clock per state.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   m{0,1}_req/we/addr/wdata    requester command, held stable until ack
//   m{0,1}_ack                  one-cycle completion pulse
//   m{0,1}_rdata                read result, held until that port's next read
//   mem_address/mem_write_data  registered bus address and write data
//   mem_read_enable/_write_enable  bus strobes, high only in ACCESS
//   imem_read_data/dmem_read_data  registered memory read data
//   busy, grant_id              FSM not idle, owner of current/last transaction
module memory_bus_arbiter #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned IMEM_WIDTH = 27,
    parameter int unsigned DMEM_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [IMEM_WIDTH-1:0] m0_wdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [IMEM_WIDTH-1:0] m1_wdata,
    output logic                  m0_ack,
    output logic [IMEM_WIDTH-1:0] m0_rdata,
    output logic                  m1_ack,
    output logic [IMEM_WIDTH-1:0] m1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [IMEM_WIDTH-1:0] mem_write_data,
    output logic                  mem_read_enable,
    output logic                  mem_write_enable,
    input  logic [IMEM_WIDTH-1:0] imem_read_data,
    input  logic [DMEM_WIDTH-1:0] dmem_read_data,
    output logic                  busy,
    output logic                  grant_id
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                  state, state_n;
    logic                    last_grant, last_grant_n;
    logic                    we_r, we_r_n;
    logic                    grant_n;
    logic                    winner;
    logic [ADDR_WIDTH-1:0]   addr_n;
    logic [IMEM_WIDTH-1:0]   wdata_n;
    logic                    re_n, wstrobe_n;
    logic                    ack0_n, ack1_n;
    logic [IMEM_WIDTH-1:0]   rdata0_n, rdata1_n;
    logic [IMEM_WIDTH-1:0]   cap_data;
    logic                    busy_n;

    // Address MSB selects instruction memory; data memory words are zero-extended.
    assign cap_data = mem_address[ADDR_WIDTH-1] ? imem_read_data
                                                : IMEM_WIDTH'(dmem_read_data);

    // Next-state and next-output logic.
    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        we_r_n       = we_r;
        grant_n      = grant_id;
        addr_n       = mem_address;
        wdata_n      = mem_write_data;
        re_n         = 1'b0;
        wstrobe_n    = 1'b0;
        ack0_n       = 1'b0;
        ack1_n       = 1'b0;
        rdata0_n     = m0_rdata;
        rdata1_n     = m1_rdata;
        winner       = 1'b0;

        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    // On a tie the port that did not win last time goes first.
                    winner       = (m0_req && m1_req) ? ~last_grant : m1_req;
                    last_grant_n = winner;
                    grant_n      = winner;
                    addr_n       = winner ? m1_addr  : m0_addr;
                    wdata_n      = winner ? m1_wdata : m0_wdata;
                    we_r_n       = winner ? m1_we    : m0_we;
                    // Strobes are registered, so set them on the grant edge to land in ACCESS.
                    wstrobe_n    = winner ? m1_we    : m0_we;
                    re_n         = winner ? ~m1_we   : ~m0_we;
                    state_n      = ACCESS;
                end
            end
            ACCESS: begin
                state_n = CAPTURE;
            end
            CAPTURE: begin
                if (!we_r) begin
                    if (grant_id) rdata1_n = cap_data;
                    else          rdata0_n = cap_data;
                end
                ack0_n  = ~grant_id;
                ack1_n  = grant_id;
                state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            last_grant       <= 1'b1;
            we_r             <= 1'b0;
            grant_id         <= 1'b0;
            mem_address      <= '0;
            mem_write_data   <= '0;
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            m0_ack           <= 1'b0;
            m1_ack           <= 1'b0;
            m0_rdata         <= '0;
            m1_rdata         <= '0;
            busy             <= 1'b0;
        end else begin
            state            <= state_n;
            last_grant       <= last_grant_n;
            we_r             <= we_r_n;
            grant_id         <= grant_n;
            mem_address      <= addr_n;
            mem_write_data   <= wdata_n;
            mem_read_enable  <= re_n;
            mem_write_enable <= wstrobe_n;
            m0_ack           <= ack0_n;
            m1_ack           <= ack1_n;
            m0_rdata         <= rdata0_n;
            m1_rdata         <= rdata1_n;
            busy             <= busy_n;
        end
    end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Testbench for memory_bus_arbiter: directed scenarios followed by random traffic,
// checked every cycle against a transaction-timeline reference model.
module tb_memory_bus_arbiter;

    localparam int unsigned AW    = 14;
    localparam int unsigned IW    = 27;
    localparam int unsigned DW    = 24;
    localparam int unsigned DEPTH = 8192;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [IW-1:0] m0_wdata, m1_wdata;
    logic          m0_ack, m1_ack;
    logic [IW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] mem_address;
    logic [IW-1:0] mem_write_data;
    logic          mem_read_enable, mem_write_enable;
    logic [IW-1:0] imem_read_data;
    logic [DW-1:0] dmem_read_data;
    logic          busy, grant_id;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    memory_bus_arbiter #(.ADDR_WIDTH(AW), .IMEM_WIDTH(IW), .DMEM_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
        .imem_read_data(imem_read_data), .dmem_read_data(dmem_read_data),
        .busy(busy), .grant_id(grant_id)
    );

    // Bus-side memories with registered read data (read-before-write).
    logic [IW-1:0] imem [DEPTH];
    logic [DW-1:0] dmem [DEPTH];
    always @(posedge clk) begin
        if (mem_read_enable) begin
            imem_read_data <= imem[mem_address[12:0]];
            dmem_read_data <= dmem[mem_address[12:0]];
        end
        if (mem_write_enable) begin
            if (mem_address[13]) imem[mem_address[12:0]] = mem_write_data;
            else                 dmem[mem_address[12:0]] = mem_write_data[23:0];
        end
    end

    // Reference model: shadow memory updated per transaction, plus a timeline
    // counter giving cycles elapsed since the grant (-1 when the bus is free).
    logic [IW-1:0] sh_imem [DEPTH];
    logic [DW-1:0] sh_dmem [DEPTH];
    int            phase = -1;
    bit            last  = 1'b1;
    bit            win;
    bit            t_we;
    logic [AW-1:0] t_addr;
    logic [IW-1:0] t_wdata, t_rd;
    bit            e_busy, e_gid, e_re, e_we;
    bit            e_ack [2];
    logic [IW-1:0] e_rdata [2];
    logic [AW-1:0] e_addr;
    logic [IW-1:0] e_wdata;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, act, exp);
        end
    endtask

    task automatic shadow_write();
        if (t_addr[13]) sh_imem[t_addr[12:0]] = t_wdata;
        else            sh_dmem[t_addr[12:0]] = t_wdata[23:0];
    endtask

    // Predict what the coming clock edge does, from the inputs now applied.
    task automatic model_edge();
        if (reset) begin
            // A write whose strobe is on the bus at this edge still lands.
            if (phase == 0 && t_we) shadow_write();
            phase = -1; last = 1'b1;
            e_busy = 0; e_gid = 0; e_re = 0; e_we = 0;
            e_ack[0] = 0; e_ack[1] = 0;
            e_rdata[0] = '0; e_rdata[1] = '0;
            e_addr = '0; e_wdata = '0;
        end else begin
            case (phase)
                -1: if (m0_req || m1_req) begin
                    win     = (m0_req && m1_req) ? !last : m1_req;
                    last    = win;
                    t_we    = win ? m1_we    : m0_we;
                    t_addr  = win ? m1_addr  : m0_addr;
                    t_wdata = win ? m1_wdata : m0_wdata;
                    e_addr  = t_addr; e_wdata = t_wdata; e_gid = win;
                    e_busy  = 1; e_re = !t_we; e_we = t_we;
                    phase   = 0;
                end
                0: begin
                    e_re = 0; e_we = 0;
                    if (t_we) shadow_write();
                    else t_rd = t_addr[13] ? sh_imem[t_addr[12:0]] : {3'b000, sh_dmem[t_addr[12:0]]};
                    phase = 1;
                end
                1: begin
                    if (!t_we) e_rdata[win] = t_rd;
                    e_ack[win] = 1;
                    phase = 2;
                end
                default: begin
                    e_ack[0] = 0; e_ack[1] = 0;
                    e_busy = 0;
                    phase = -1;
                end
            endcase
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check("busy",     32'(busy),             32'(e_busy));
        check("grant_id", 32'(grant_id),         32'(e_gid));
        check("rd_en",    32'(mem_read_enable),  32'(e_re));
        check("wr_en",    32'(mem_write_enable), 32'(e_we));
        check("m0_ack",   32'(m0_ack),           32'(e_ack[0]));
        check("m1_ack",   32'(m1_ack),           32'(e_ack[1]));
        check("m0_rdata", 32'(m0_rdata),         32'(e_rdata[0]));
        check("m1_rdata", 32'(m1_rdata),         32'(e_rdata[1]));
        check("mem_addr", 32'(mem_address),      32'(e_addr));
        check("mem_wdat", 32'(mem_write_data),   32'(e_wdata));
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = '0;
        a[13]  = 1'($urandom_range(1));
        a[3:0] = 4'($urandom_range(15));
        return a;
    endfunction

    // Requesters: drop req after an ack; otherwise raise a fresh random request with chance pct.
    task automatic drive(input int pct);
        if (!m0_req) begin
            if (int'($urandom_range(99)) < pct) begin
                m0_req = 1; m0_we = 1'($urandom_range(1));
                m0_addr = rand_addr(); m0_wdata = 27'($urandom);
            end
        end else if (e_ack[0]) m0_req = 0;
        if (!m1_req) begin
            if (int'($urandom_range(99)) < pct) begin
                m1_req = 1; m1_we = 1'($urandom_range(1));
                m1_addr = rand_addr(); m1_wdata = 27'($urandom);
            end
        end else if (e_ack[1]) m1_req = 0;
    endtask

    task automatic run(input int n, input int pct);
        for (int i = 0; i < n; i++) begin
            cycle();
            drive(pct);
        end
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            imem[i] = 27'($urandom); sh_imem[i] = imem[i];
            dmem[i] = 24'($urandom); sh_dmem[i] = dmem[i];
        end
        imem[0] = 27'h2800010; sh_imem[0] = 27'h2800010;

        // Reset with random inputs applied.
        reset = 1;
        m0_req = 1'($urandom_range(1)); m0_we = 1'($urandom_range(1));
        m0_addr = 14'($urandom); m0_wdata = 27'($urandom);
        m1_req = 1'($urandom_range(1)); m1_we = 1'($urandom_range(1));
        m1_addr = 14'($urandom); m1_wdata = 27'($urandom);
        run(2, 0);
        reset = 0;

        // Tie after reset: m0 imem read wins, then m1 dmem write, then m1 reads it back.
        m0_req = 1; m0_we = 0; m0_addr = 14'h2000;
        m1_req = 1; m1_we = 1; m1_addr = 14'h0030; m1_wdata = 27'h7ABCDEF;
        run(8, 0);
        m1_req = 1; m1_we = 0; m1_addr = 14'h0030;
        run(5, 0);
        check("m1_zext", 32'(m1_rdata), 32'h0ABCDEF);

        // Both ports continuously re-requesting: grants alternate.
        run(16, 100);
        run(6, 0);

        // Reset during CAPTURE of an m0 read; held req is reissued.
        m0_req = 1; m0_we = 0; m0_addr = 14'h2001;
        run(2, 0);
        reset = 1;
        run(1, 0);
        reset = 0;
        run(6, 0);

        // Late request from m1 while m0 is in ACCESS.
        m0_req = 1; m0_we = 0; m0_addr = 14'h0005;
        run(1, 0);
        m1_req = 1; m1_we = 1; m1_addr = 14'h2003; m1_wdata = 27'h1234567;
        run(9, 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(199) == 0);
            run(1, 40);
        end
        reset = 0;
        run(8, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
